// File: rtl/bus_if.sv
// Purpose: master-side bus interface; SPM hits served combinationally, misses become bus transactions.
// Latency: SPM access 0 cycles; bus access busy for request + grant + ready-wait cycles (min 2).
// Backpressure: busy stalls the pipeline while a bus transaction is outstanding.
//
// Ports:
//   clk, reset                        clock (rising edge), synchronous active-high reset
//   stall, flush, busy                pipeline control in / stall request out
//   addr, as_, rw, wr_data, rd_data   CPU access (word address, active-low strobe, 1=read)
//   spm_*                             scratchpad pass-through and strobe
//   bus_req_, bus_grnt_               arbiter handshake (active low)
//   bus_addr, bus_as_, bus_rw,
//   bus_wr_data, bus_rd_data, bus_rdy_  registered bus access and slave response
module bus_if #(
  parameter int          ADDR_W  = 30,
  parameter int          DATA_W  = 32,
  parameter logic [2:0]  SPM_SEL = 3'b011
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  output logic              busy,
  input  logic [ADDR_W-1:0] addr,
  input  logic              as_,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] rd_buf;
  logic              hit;
  logic              valid;

  assign hit   = (addr[ADDR_W-1 -: 3] == SPM_SEL);
  assign valid = !as_ && !flush;

  // The SPM sees the CPU access unmodified; only its strobe is gated.
  assign spm_addr    = addr;
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rd_data   = '0;
    spm_as_   = 1'b1;
    case (state)
      IDLE: begin
        if (valid && hit) begin
          spm_as_ = 1'b0;
          rd_data = rw ? spm_rd_data : '0;
        end else if (valid) begin
          busy      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        busy = 1'b1;
        if (!bus_grnt_) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!bus_rdy_) begin
          // Ready releases the pipeline in the same cycle; rd_buf keeps the
          // data visible if the pipeline is stalled by someone else.
          rd_data   = bus_rd_data;
          state_nxt = stall ? STALL : IDLE;
        end else begin
          busy = 1'b1;
        end
      end
      STALL: begin
        rd_data = rd_buf;
        if (!stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_rw      <= 1'b1;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      rd_buf      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (valid && !hit) begin
            bus_req_    <= 1'b0;
            bus_addr    <= addr;
            bus_rw      <= rw;
            bus_wr_data <= wr_data;
          end
        end
        REQ: begin
          if (!bus_grnt_) bus_as_ <= 1'b0;
        end
        ACCESS: begin
          // Strobe lasts one cycle; request stays low until ready so the
          // arbiter does not hand the bus away mid-transaction.
          bus_as_ <= 1'b1;
          if (!bus_rdy_) begin
            rd_buf      <= bus_rd_data;
            bus_req_    <= 1'b1;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            bus_rw      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_if.sv
module tb_bus_if;
  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, stall, flush, busy;
  logic [AW-1:0] addr;
  logic          as_, rw;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW-1:0] spm_addr;
  logic          spm_as_, spm_rw;
  logic [DW-1:0] spm_wr_data, spm_rd_data;
  logic          bus_req_, bus_grnt_;
  logic [AW-1:0] bus_addr;
  logic          bus_as_, bus_rw;
  logic [DW-1:0] bus_wr_data, bus_rd_data;
  logic          bus_rdy_;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_if dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .addr(addr), .as_(as_), .rw(rw), .wr_data(wr_data), .rd_data(rd_data),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_addr(bus_addr),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  function automatic logic [AW-1:0] hit_addr();
    logic [26:0] lo;
    lo = 27'($urandom);
    return {3'b011, lo};
  endfunction

  function automatic logic [AW-1:0] miss_addr();
    logic [2:0]  top;
    logic [26:0] lo;
    do top = 3'($urandom_range(0, 7)); while (top == 3'b011);
    lo = 27'($urandom);
    return {top, lo};
  endfunction

  // One full bus transaction, described by its phases: an issue cycle, gd
  // waiting REQ cycles then the granted one, rd ACCESS cycles without ready then
  // the ready one, ns STALL cycles, then an idle cycle.
  // fmode: 0 flush low, 1 flush high, 2 random flush while the transaction runs.
  task automatic run_txn(input logic [AW-1:0] a, input logic r, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rdat, input int gd, input int rd,
                         input int ns, input int fmode, input string nm);
    logic [3:0] exp_ctl;
    logic [DW-1:0] exp_rd;
    @(negedge clk);
    as_ = 1'b0; addr = a; rw = r; wr_data = wd; flush = 1'b0;
    stall = 1'($urandom); bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    #1;
    total++;
    if ({busy, bus_req_, spm_as_} !== 3'b111) begin
      bad++; $display("FAIL %s issue {busy,req_,spm_as_}=%b want 111", nm, {busy, bus_req_, spm_as_});
    end
    for (int k = 0; k <= gd; k++) begin
      @(negedge clk);
      bus_grnt_ = (k == gd) ? 1'b0 : 1'b1;
      flush = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'($urandom) : 1'b0;
      addr = miss_addr(); wr_data = $urandom; rw = 1'($urandom); stall = 1'($urandom);
      #1;
      total++;
      if ({busy, bus_req_, bus_as_, spm_as_} !== 4'b1011 || bus_addr !== a ||
          bus_rw !== r || bus_wr_data !== wd) begin
        bad++;
        $display("FAIL %s req%0d ctl=%b addr=%h rw=%b wd=%h want 1011 %h %b %h", nm, k,
                 {busy, bus_req_, bus_as_, spm_as_}, bus_addr, bus_rw, bus_wr_data, a, r, wd);
      end
    end
    for (int j = 0; j <= rd; j++) begin
      @(negedge clk);
      bus_grnt_ = 1'b1;
      bus_rdy_ = (j == rd) ? 1'b0 : 1'b1;
      bus_rd_data = (j == rd) ? rdat : $urandom;
      stall = (j == rd) ? (ns > 0) : 1'($urandom);
      flush = (fmode == 1) ? 1'b1 : (fmode == 2) ? 1'($urandom) : 1'b0;
      #1;
      exp_ctl = {(j < rd), 1'b0, (j != 0), 1'b1};
      exp_rd  = (j == rd) ? rdat : '0;
      total++;
      if ({busy, bus_req_, bus_as_, spm_as_} !== exp_ctl || rd_data !== exp_rd ||
          bus_addr !== a || bus_rw !== r || bus_wr_data !== wd) begin
        bad++;
        $display("FAIL %s acc%0d ctl=%b rd=%h addr=%h rw=%b wd=%h want %b %h %h %b %h", nm, j,
                 {busy, bus_req_, bus_as_, spm_as_}, rd_data, bus_addr, bus_rw, bus_wr_data,
                 exp_ctl, exp_rd, a, r, wd);
      end
    end
    for (int i = 0; i < ns; i++) begin
      @(negedge clk);
      bus_rdy_ = 1'b1; bus_rd_data = $urandom;
      stall = (i < ns - 1) ? 1'b1 : 1'b0;
      as_ = 1'b0; addr = miss_addr(); flush = 1'b0;
      #1;
      total++;
      if ({busy, bus_req_, bus_as_, spm_as_} !== 4'b0111 || rd_data !== rdat ||
          bus_addr !== '0 || bus_rw !== 1'b1 || bus_wr_data !== '0) begin
        bad++;
        $display("FAIL %s stall%0d ctl=%b rd=%h addr=%h rw=%b wd=%h want 0111 %h 0 1 0", nm, i,
                 {busy, bus_req_, bus_as_, spm_as_}, rd_data, bus_addr, bus_rw, bus_wr_data, rdat);
      end
    end
    @(negedge clk);
    as_ = 1'b1; flush = 1'b0; stall = 1'b0; bus_rdy_ = 1'b1;
    #1;
    total++;
    if ({busy, bus_req_, bus_as_, spm_as_} !== 4'b0111 || rd_data !== '0 || bus_addr !== '0) begin
      bad++;
      $display("FAIL %s done ctl=%b rd=%h addr=%h want 0111 0 0", nm,
               {busy, bus_req_, bus_as_, spm_as_}, rd_data, bus_addr);
    end
  endtask

  task automatic spm_access(input logic r, input string nm);
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = hit_addr(); d = $urandom;
    @(negedge clk);
    as_ = 1'b0; addr = a; rw = r; wr_data = $urandom; spm_rd_data = d;
    flush = 1'b0; stall = 1'($urandom);
    #1;
    total++;
    if ({busy, bus_req_, spm_as_} !== 3'b010 || rd_data !== (r ? d : '0) ||
        spm_addr !== a || spm_rw !== r || spm_wr_data !== wr_data) begin
      bad++;
      $display("FAIL %s {busy,req_,spm_as_}=%b rd=%h want 010 %h", nm,
               {busy, bus_req_, spm_as_}, rd_data, r ? d : '0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; as_ = 1'b1; addr = '0; rw = 1'b1;
    wr_data = '0; spm_rd_data = '0; bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if ({busy, bus_req_, bus_as_, bus_rw, spm_as_} !== 5'b01111 || rd_data !== '0 ||
        bus_addr !== '0 || bus_wr_data !== '0) begin
      bad++;
      $display("FAIL reset ctl=%b rd=%h addr=%h wd=%h want 01111 0 0 0",
               {busy, bus_req_, bus_as_, bus_rw, spm_as_}, rd_data, bus_addr, bus_wr_data);
    end
  endtask

  task automatic test_spm();
    for (int i = 0; i < 6; i++) spm_access(1'(i % 2), "spm");
    @(negedge clk);
    as_ = 1'b1;
    #1;
    total++;
    if ({busy, bus_req_, spm_as_} !== 3'b011 || rd_data !== '0) begin
      bad++; $display("FAIL spm_idle ctl=%b rd=%h want 011 0", {busy, bus_req_, spm_as_}, rd_data);
    end
  endtask

  task automatic test_bus_read();
    run_txn(30'h100, 1'b1, 32'h0, 32'h12345678, 2, 3, 0, 0, "bus_read");
  endtask

  task automatic test_bus_write_stall();
    run_txn(miss_addr(), 1'b0, 32'hCAFE0001, $urandom, 0, 0, 2, 0, "bus_write");
  endtask

  task automatic test_flush();
    @(negedge clk);
    as_ = 1'b0; addr = miss_addr(); rw = 1'b1; flush = 1'b1; stall = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || spm_as_ !== 1'b1) begin
      bad++; $display("FAIL flush_idle busy=%b spm_as_=%b want 0 1", busy, spm_as_);
    end
    @(negedge clk);
    as_ = 1'b1; flush = 1'b0;
    #1;
    total++;
    if (bus_req_ !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL flush_noreq req_=%b busy=%b want 1 0", bus_req_, busy);
    end
    run_txn(miss_addr(), 1'b1, $urandom, $urandom, 1, 1, 0, 1, "flush_req");
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    a = miss_addr();
    @(negedge clk);
    as_ = 1'b0; addr = a; rw = 1'b0; wr_data = $urandom; flush = 1'b0; stall = 1'b0;
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    @(negedge clk);
    bus_grnt_ = 1'b0;
    @(negedge clk);
    bus_grnt_ = 1'b1; reset = 1'b1;
    #1;
    total++;
    if ({busy, bus_as_} !== 2'b10) begin
      bad++; $display("FAIL rst_mid_acc {busy,as_}=%b want 10", {busy, bus_as_});
    end
    @(negedge clk);
    reset = 1'b0; as_ = 1'b1;
    #1;
    total++;
    if ({busy, bus_req_, bus_as_, bus_rw} !== 4'b0111 || bus_addr !== '0 || bus_wr_data !== '0) begin
      bad++;
      $display("FAIL rst_mid ctl=%b addr=%h wd=%h want 0111 0 0",
               {busy, bus_req_, bus_as_, bus_rw}, bus_addr, bus_wr_data);
    end
    @(negedge clk);
    #1;
    total++;
    if ({busy, bus_req_} !== 2'b01) begin
      bad++; $display("FAIL rst_mid_idle {busy,req_}=%b want 01", {busy, bus_req_});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) spm_access(1'($urandom), "rand_spm");
      else run_txn(miss_addr(), 1'($urandom), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 2, "rand_bus");
    end
  endtask

  initial begin
    test_reset();
    test_spm();
    test_bus_read();
    test_bus_write_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
